// File: rtl/m602.sv
// Dual pulse amplifier: each channel turns a qualified 1->0 trigger edge into a
// fixed-width registered pulse plus a registered complement, then locks out.
module m602 #(
  parameter int unsigned PW  = 5,
  parameter int unsigned REC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic D1,
  input  logic E1,
  input  logic F1,
  output logic H1,
  output logic J1,
  input  logic K1,
  input  logic L1,
  input  logic M1,
  output logic N1,
  output logic P1
);

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam logic [CW-1:0] PW_LD  = CW'(PW - 1);
  localparam logic [CW-1:0] REC_LD = CW'(REC - 1);
  localparam bit HAS_REC = (REC != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [CW-1:0]     cnt_q   [NCH];
  logic [CW-1:0]     cnt_d   [NCH];
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    arm;
  logic [NCH-1:0]    trig_q;
  logic [NCH-1:0]    pulse_d;
  logic [NCH-1:0]    pulse_q;
  logic [NCH-1:0]    pulse_n_q;

  assign trig = {M1, F1};
  assign arm  = {K1 & L1, D1 & E1};

  // State, counter, trigger history and both output polarities.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      trig_q    <= '0;
      pulse_q   <= '0;
      pulse_n_q <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      trig_q    <= trig;
      pulse_q   <= pulse_d;
      pulse_n_q <= ~pulse_d;
    end
  end

  // Per-channel next state; pulse_d is the output level after this edge.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (trig_q[i] && !trig[i] && arm[i]) begin
            state_d[i] = PULSE;
            cnt_d[i]   = PW_LD;
            pulse_d[i] = 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i]   = cnt_q[i] - CW'(1);
            pulse_d[i] = 1'b1;
          end else if (HAS_REC) begin
            state_d[i] = RECOVER;
            cnt_d[i]   = REC_LD;
          end else begin
            state_d[i] = IDLE;
          end
        end
        RECOVER: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end else begin
            state_d[i] = IDLE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign H1 = pulse_q[0];
  assign J1 = pulse_n_q[0];
  assign N1 = pulse_q[1];
  assign P1 = pulse_n_q[1];

endmodule
